// File: rtl/fifo_cmp_pkg.sv
// Shared types and widths for the compare-run monitor slice.
//   DATA_W : width of the upstream data word
//   LEN_W  : width of a run length (runs never exceed 511 beats)
//   CNT_W  : width of the emitted-record counter
//   state_e: run tracker states
//   rec_t  : run record payload {len, data}
`timescale 1ns/1ps
package fifo_cmp_pkg;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned LEN_W  = 9;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } rec_t;

endpackage

// File: rtl/comp_run_monitor_if.sv
// Bus bundle for comp_run_monitor.
//   upstream  : in_valid, in_data, in_comp -> in_ready
//   control   : flush
//   downstream: out_valid, out_len, out_data <- out_ready
//   status    : run_count
// master = the side driving beats and consuming records; slave = the monitor.
`timescale 1ns/1ps
interface comp_run_monitor_if;
  import fifo_cmp_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_comp;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [LEN_W-1:0]  out_len;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  run_count;

  modport master (
    output in_valid, in_data, in_comp, flush, out_ready,
    input  in_ready, out_valid, out_len, out_data, run_count
  );

  modport slave (
    input  in_valid, in_data, in_comp, flush, out_ready,
    output in_ready, out_valid, out_len, out_data, run_count
  );

endinterface

// File: rtl/cmp_rec_fifo2.sv
// Two-entry in-order record buffer. Entry 0 is always the head, so the
// head outputs come straight from a register and stay stable until popped.
//   clk, rst   : clock, async active-low reset
//   push, wr   : write a record (caller only pushes when not full)
//   pop        : consume the head (ignored when empty)
//   head       : head record
//   head_valid : buffer is non-empty
//   full       : buffer holds two records
`timescale 1ns/1ps
module cmp_rec_fifo2
  import fifo_cmp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t wr,
  input  logic pop,
  output rec_t head,
  output logic head_valid,
  output logic full
);

  rec_t e0_q, e1_q;
  logic v0_q, v1_q;
  logic do_pop, do_push;

  assign do_pop  = pop && v0_q;
  // A push into a full buffer is only allowed when the head leaves in the same cycle.
  assign do_push = push && (!v1_q || do_pop);

  // Shift-register storage: pops move entry 1 down into entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0_q <= '0;
      e1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (!v0_q) begin
            e0_q <= wr;
            v0_q <= 1'b1;
          end else begin
            e1_q <= wr;
            v1_q <= 1'b1;
          end
        end
        2'b01: begin
          e0_q <= e1_q;
          v0_q <= v1_q;
          v1_q <= 1'b0;
        end
        2'b11: begin
          if (v1_q) begin
            e0_q <= e1_q;
            e1_q <= wr;
          end else begin
            e0_q <= wr;
          end
        end
        default: ;
      endcase
    end
  end

  assign head       = e0_q;
  assign head_valid = v0_q;
  assign full       = v1_q;

endmodule

// File: rtl/comp_run_monitor.sv
// Tracks runs of consecutive compare hits and emits {length, first word}
// records for runs of at least MIN_RUN beats; runs reaching MAX_RUN are
// cut and reported immediately. Records queue in a 2-entry buffer.
//   clk, rst : clock, async active-low reset
//   bus      : upstream beats, flush, downstream records, run_count
`timescale 1ns/1ps
module comp_run_monitor
  import fifo_cmp_pkg::*;
#(
  parameter int unsigned MIN_RUN = 4,
  parameter int unsigned MAX_RUN = 511
) (
  input  logic                clk,
  input  logic                rst,
  comp_run_monitor_if.slave   bus
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_RUN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_RUN);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] start_q, start_d;
  logic [CNT_W-1:0]  run_count_q;

  logic push_c;
  rec_t push_rec_c;
  rec_t head;
  logic head_valid, fifo_full;
  logic space_c, accept_c, pop_c;
  logic [LEN_W-1:0] count_inc_c;

  assign space_c     = !fifo_full;
  assign bus.in_ready = space_c && !bus.flush;
  assign accept_c    = bus.in_valid && bus.in_ready;
  assign pop_c       = head_valid && bus.out_ready;
  assign count_inc_c = LEN_W'(count_q + LEN_W'(1));

  // State register and run bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      start_q <= start_d;
    end
  end

  // Next state and record generation.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    start_d    = start_q;
    push_c     = 1'b0;
    push_rec_c = '0;
    case (state_q)
      IDLE: begin
        if (accept_c && bus.in_comp) begin
          if (MAX_RUN == 1) begin
            // A single hit already reaches the cap.
            push_c          = 1'b1;
            push_rec_c.len  = LEN_W'(1);
            push_rec_c.data = bus.in_data;
          end else begin
            state_d = RUN;
            count_d = LEN_W'(1);
            start_d = bus.in_data;
          end
        end
      end
      RUN: begin
        // Flush blocks in_ready, so it never coincides with an accepted beat.
        if (bus.flush && space_c) begin
          if (count_q >= MIN_L) begin
            push_c          = 1'b1;
            push_rec_c.len  = count_q;
            push_rec_c.data = start_q;
          end
          state_d = IDLE;
          count_d = '0;
        end else if (accept_c) begin
          if (bus.in_comp) begin
            if (count_inc_c == MAX_L) begin
              push_c          = 1'b1;
              push_rec_c.len  = MAX_L;
              push_rec_c.data = start_q;
              state_d         = IDLE;
              count_d         = '0;
            end else begin
              count_d = count_inc_c;
            end
          end else begin
            if (count_q >= MIN_L) begin
              push_c          = 1'b1;
              push_rec_c.len  = count_q;
              push_rec_c.data = start_q;
            end
            state_d = IDLE;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  cmp_rec_fifo2 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_c),
    .wr         (push_rec_c),
    .pop        (pop_c),
    .head       (head),
    .head_valid (head_valid),
    .full       (fifo_full)
  );

  // Count of records handed downstream, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_count_q <= '0;
    end else if (pop_c && (run_count_q != {CNT_W{1'b1}})) begin
      run_count_q <= CNT_W'(run_count_q + CNT_W'(1));
    end
  end

  assign bus.out_valid = head_valid;
  assign bus.out_len   = head.len;
  assign bus.out_data  = head.data;
  assign bus.run_count = run_count_q;

endmodule

// File: tb/tb_comp_run_monitor.sv
`timescale 1ns/1ps
module tb_comp_run_monitor;
  import fifo_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  comp_run_monitor_if bus();

  comp_run_monitor #(.MIN_RUN(4), .MAX_RUN(511)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   exp_runs = 0;
  rec_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int len, input logic [23:0] d);
    rec_t r;
    r.len  = LEN_W'(len);
    r.data = d;
    exp_q.push_back(r);
    exp_runs++;
  endtask

  // Scoreboard monitor: compare each record as it is handed off.
  always @(negedge clk) begin : mon
    rec_t e;
    if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_record: got len=%0d data=0x%0h want none", bus.out_len, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("rec_len", 32'(bus.out_len), 32'(e.len));
        chk("rec_data", 32'(bus.out_data), 32'(e.data));
      end
    end
  end

  // Drive one beat and return at posedge+1 of the accepting edge.
  task automatic beat(input logic c, input logic [23:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_comp  = c;
    bus.in_data  = d;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got in_ready=%0b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain_and_count(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_run_count"}, 32'(bus.run_count), 32'(exp_runs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_comp   = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_len", 32'(bus.out_len), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_run_count", 32'(bus.run_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    idle(1);

    // Short run below MIN_RUN is discarded
    beat(1'b1, 24'h000001);
    beat(1'b1, 24'h000002);
    beat(1'b1, 24'h000003);
    beat(1'b0, 24'h000004);
    idle(3);
    chk("short_out_valid", 32'(bus.out_valid), 32'd0);
    drain_and_count("short");

    // Basic run of 5 hits framed by misses
    beat(1'b0, 24'h000010);
    for (int i = 1; i <= 5; i++) beat(1'b1, 24'(24'h000010 + i));
    push_exp(5, 24'h000011);
    beat(1'b0, 24'h000016);
    @(negedge clk);
    chk("basic_valid_next_cycle", 32'(bus.out_valid), 32'd1);
    drain_and_count("basic");

    // Reset mid-run with a record waiting
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b1, 24'(24'h0000A0 + i));
    beat(1'b0, 24'h0000AF);
    beat(1'b1, 24'h0000B0);
    beat(1'b1, 24'h0000B1);
    @(negedge clk);
    chk("rstmid_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstmid_out_len", 32'(bus.out_len), 32'd0);
    chk("rstmid_run_count", 32'(bus.run_count), 32'd0);
    exp_runs = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    idle(10);
    chk("rstmid_post_valid", 32'(bus.out_valid), 32'd0);
    drain_and_count("rstmid");

    // 600 hits: one capped record, then the remainder
    push_exp(511, 24'h100001);
    push_exp(89, 24'(24'h100000 + 512));
    for (int i = 1; i <= 600; i++) beat(1'b1, 24'(24'h100000 + i));
    beat(1'b0, 24'h1FFFFF);
    drain_and_count("maxrun");

    // Backpressure: buffer fills after two records
    bus.out_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) beat(1'b1, 24'(24'h200000 + r * 16 + j));
      push_exp(4, 24'(24'h200000 + r * 16));
      beat(1'b0, 24'h2000FF);
    end
    bus.in_valid = 1'b1;
    bus.in_comp  = 1'b1;
    bus.in_data  = 24'h200020;
    @(negedge clk);
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    chk("bp_head_len", 32'(bus.out_len), 32'd4);
    chk("bp_head_data", 32'(bus.out_data), 32'h200000);
    idle(3);
    chk("bp_head_stable", 32'(bus.out_data), 32'h200000);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) beat(1'b1, 24'(24'h200020 + j));
    push_exp(4, 24'h200020);
    beat(1'b0, 24'h2000FF);
    drain_and_count("bp");

    // Flush terminates an open 6-beat run
    for (int j = 0; j < 6; j++) beat(1'b1, 24'(24'h300000 + j));
    push_exp(6, 24'h300000);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_comp  = 1'b1;
    bus.in_data  = 24'hABCDEF;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd1);
    drain_and_count("flush");

    // Flush while idle does nothing
    bus.flush = 1'b1;
    idle(2);
    bus.flush = 1'b0;
    idle(2);
    chk("flush_idle_valid", 32'(bus.out_valid), 32'd0);
    drain_and_count("flush_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comp_run_monitor.md
COMP_RUN_MONITOR -- requirements
Module: comp_run_monitor

Interface
REQ-001 The block SHALL have parameter MIN_RUN, default 4, giving the minimum match-run length that is reported (legal range 1..MAX_RUN).
REQ-002 The block SHALL have parameter MAX_RUN, default 511, giving the run length at which a record is forced out (legal range MIN_RUN..511).
REQ-003 The block SHALL have one clock and one reset: clk, input, 1 bit, rising-edge clock; rst, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have in_valid, input, 1 bit: an upstream beat is present.
REQ-005 The block SHALL have in_data, input, 24 bits: the upstream data word (the compare stage's dout).
REQ-006 The block SHALL have in_comp, input, 1 bit: the compare flag for this beat (the compare stage's comp).
REQ-007 The block SHALL have in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-008 The block SHALL have flush, input, 1 bit: terminate any open run now.
REQ-009 The block SHALL have out_valid, output, 1 bit: a run record is present.
REQ-010 The block SHALL have out_ready, input, 1 bit: downstream accepts the record.
REQ-011 The block SHALL have out_len, output, 9 bits: the run length of the head record.
REQ-012 The block SHALL have out_data, output, 24 bits: the first data word of the head record's run.
REQ-013 The block SHALL have run_count, output, 16 bits: the number of records emitted, saturating at 0xFFFF.

Function
REQ-014 An accepted beat SHALL be defined as in_valid && in_ready on a clk rising edge.
REQ-015 in_ready SHALL be 1 exactly when flush=0 and the record buffer holds fewer than 2 entries.
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 In IDLE, an accepted beat with in_comp=1 SHALL capture in_data as start word, set count=1 and go to RUN; a beat with in_comp=0 SHALL stay in IDLE with no effect.
REQ-018 In RUN, an accepted beat with in_comp=1 SHALL increment count; if the new count equals MAX_RUN, the block SHALL push record {MAX_RUN, start word} and go to IDLE.
REQ-019 In RUN, an accepted beat with in_comp=0 SHALL push {count, start word} if count >= MIN_RUN, otherwise discard the run, and SHALL go to IDLE; that beat does not start a new run.
REQ-020 flush=1 in RUN SHALL push {count, start word} if count >= MIN_RUN and go to IDLE; flush acts only when the buffer has space (in_ready would be 1 with flush ignored), otherwise it is ignored and must be held.
REQ-021 flush=1 in IDLE SHALL have no effect.
REQ-022 A pushed record SHALL appear on out_* (out_valid=1) on the cycle after the terminating edge if the buffer was empty.
REQ-023 The record buffer SHALL be 2-entry in-order; pop on out_valid && out_ready; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-024 out_len/out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 run_count SHALL increment by 1 on every pop and saturate at 0xFFFF.

Reset
REQ-026 rst=0 SHALL asynchronously force state=IDLE, count=0, buffer empty, out_valid=0, out_len=0, out_data=0 and run_count=0, with in_ready=1 after release.
REQ-027 Reset asserted mid-run or with buffered records SHALL discard them without emitting anything.

Structure
REQ-028 Package fifo_cmp_pkg SHALL hold DATA_W=24, LEN_W=9, the state enum (IDLE, RUN) and the record struct {len, data}.
REQ-029 The 2-entry record buffer SHALL be the sub-module cmp_rec_fifo2.

Verification
REQ-030 Bench SHALL check: rst=0 pulse mid-run with out_valid=1 -> out_valid=0, out_len=0, run_count=0 immediately; no record after release.
REQ-031 Bench SHALL check: out_ready=1, comp sequence 0,1,1,1,1,1,0 with data 0x000010..0x000016 -> one record len=5, data=0x000011, out_valid the cycle after the 0x000016 beat.
REQ-032 Bench SHALL check: comp sequence 1,1,1,0 with MIN_RUN=4 -> no record; run_count stays 0.
REQ-033 Bench SHALL check: 600 consecutive comp=1 beats then comp=0 -> records len=511, then len=89 with data equal to beat 512's word; run_count=2.
REQ-034 Bench SHALL check: out_ready=0 and three qualifying runs -> in_ready=0 after the second record; after out_ready=1, all three records emerge in order.
REQ-035 Bench SHALL check: 6-beat open run, then flush=1 with in_valid=1 -> in_ready=0 that cycle; record len=6 is emitted.
